// File: rtl/tlu_pkg.sv
// Shared types for the TLU trigger core: FSM state encoding, status counter
// width and a saturating increment helper.
package tlu_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_FIRE    = 2'd2,
    ST_HOLDOFF = 2'd3
  } tlu_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/tlu_evt_fifo.sv
// Event FIFO for trigger records. A push into a full FIFO is refused even when
// a pop happens in the same cycle; data at the head holds while stalled.
module tlu_evt_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign valid   = (count_q != '0);
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  assign data    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/tlu_trigger_core.sv
// TLU trigger core: coincidence/veto detection, prescaled trigger FSM with
// holdoff, event FIFO and status counters. Define TLU_TEST_PULSE_EN to add
// the TEST_PULSE input that forces RAW.
module tlu_trigger_core
  import tlu_pkg::*;
#(
  parameter int N_IN      = 4,
  parameter int N_OUT     = 6,
  parameter int TID_W     = 32,
  parameter int TS_W      = 64,
  parameter int EVT_DEPTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic                  CONF_ENABLE,
  input  logic [N_IN-1:0]       IN_VALID,
  input  logic [N_IN*8-1:0]     IN_LE_REL,
  input  logic [N_IN-1:0]       CONF_EN_INPUT,
  input  logic [N_IN-1:0]       CONF_VETO_INPUT,
  input  logic [7:0]            CONF_MAX_LE_DIST,
  input  logic [15:0]           CONF_PRESCALE,
  input  logic [7:0]            CONF_HOLDOFF,
  input  logic [N_OUT-1:0]      CONF_EN_OUTPUT,
  input  logic [N_OUT-1:0]      DUT_READY,
`ifdef TLU_TEST_PULSE_EN
  input  logic                  TEST_PULSE,
`endif
  output logic                  TRIG,
  output logic [TID_W-1:0]      TRIG_ID,
  output logic                  EVT_VALID,
  input  logic                  EVT_READY,
  output logic [TID_W+TS_W-1:0] EVT_DATA,
  output logic [23:0]           STAT_CNT,
  output tlu_state_e            DBG_STATE
);

  tlu_state_e       state_q, state_d;
  logic [TS_W-1:0]  ts_q, ts_d, ts_cap_q, ts_cap_d;
  logic [TID_W-1:0] tid_q, tid_d;
  logic [15:0]      presc_q, presc_d;
  logic [7:0]       hold_q, hold_d;
  logic [CNT_W-1:0] lost_q, lost_d, veto_cnt_q, veto_cnt_d, skip_q, skip_d;
  logic             raw_prev_q, raw_prev_d, edge_q, edge_d, veto_q, veto_d;

  logic             raw, raw_coinc, veto_now, dut_ok;
  logic [7:0]       le_i, le_max, le_min, le_span;
  logic             fire, push, armed_edge;
  logic             inc_veto, inc_skip, presc_hit, presc_inc;
  logic             fifo_full, fifo_valid;
  logic [TID_W+TS_W-1:0] fifo_data;

  // Coincidence: all enabled channels valid and their edges within the window.
  always_comb begin
    le_i   = '0;
    le_max = '0;
    le_min = '1;
    for (int i = 0; i < N_IN; i++) begin
      if (CONF_EN_INPUT[i]) begin
        le_i = IN_LE_REL[i*8 +: 8];
        if (le_i > le_max) le_max = le_i;
        if (le_i < le_min) le_min = le_i;
      end
    end
    le_span   = le_max - le_min;
    raw_coinc = (CONF_EN_INPUT != '0) &&
                ((IN_VALID & CONF_EN_INPUT) == CONF_EN_INPUT) &&
                (le_span < CONF_MAX_LE_DIST);
  end

`ifdef TLU_TEST_PULSE_EN
  assign raw = raw_coinc | TEST_PULSE;
`else
  assign raw = raw_coinc;
`endif

  assign veto_now = |(IN_VALID & CONF_VETO_INPUT);
  assign dut_ok   = ((DUT_READY & CONF_EN_OUTPUT) == CONF_EN_OUTPUT);

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!RST_N || START) state_q <= ST_IDLE;
    else                 state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (CONF_ENABLE) state_d = ST_ARMED;
      ST_ARMED: begin
        if (!CONF_ENABLE)   state_d = ST_IDLE;
        else if (presc_hit) state_d = ST_FIRE;
      end
      ST_FIRE: begin
        if (!CONF_ENABLE)              state_d = ST_IDLE;
        else if (CONF_HOLDOFF != 8'd0) state_d = ST_HOLDOFF;
        else                           state_d = ST_ARMED;
      end
      ST_HOLDOFF: begin
        if (!CONF_ENABLE)        state_d = ST_IDLE;
        else if (hold_q <= 8'd1) state_d = ST_ARMED;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; veto outranks DUT-busy, which outranks prescaling.
  always_comb begin
    fire       = (state_q == ST_FIRE);
    push       = fire && !START;
    armed_edge = (state_q == ST_ARMED) && CONF_ENABLE && edge_q;
    inc_veto   = armed_edge && veto_q;
    inc_skip   = (armed_edge && !veto_q && !dut_ok) ||
                 ((state_q == ST_HOLDOFF) && edge_q);
    presc_hit  = armed_edge && !veto_q && dut_ok && (presc_q == CONF_PRESCALE);
    presc_inc  = armed_edge && !veto_q && dut_ok && (presc_q != CONF_PRESCALE);
  end

  always_comb begin
    ts_d       = (ts_q == '1) ? ts_q : ts_q + TS_W'(1);
    ts_cap_d   = edge_q ? ts_q : ts_cap_q;
    tid_d      = fire ? tid_q + TID_W'(1) : tid_q;
    presc_d    = presc_q;
    if (presc_hit)      presc_d = '0;
    else if (presc_inc) presc_d = presc_q + 16'd1;
    hold_d     = hold_q;
    if (fire)                                           hold_d = CONF_HOLDOFF;
    else if ((state_q == ST_HOLDOFF) && (hold_q != '0)) hold_d = hold_q - 8'd1;
    lost_d     = (push && fifo_full) ? sat_inc(lost_q) : lost_q;
    veto_cnt_d = inc_veto ? sat_inc(veto_cnt_q) : veto_cnt_q;
    skip_d     = inc_skip ? sat_inc(skip_q) : skip_q;
    raw_prev_d = raw;
    edge_d     = raw && !raw_prev_q;
    veto_d     = veto_now;
  end

  // START and reset share the same initial state.
  always_ff @(posedge CLK) begin
    if (!RST_N || START) begin
      ts_q       <= TS_W'(1);
      ts_cap_q   <= '0;
      tid_q      <= '0;
      presc_q    <= '0;
      hold_q     <= '0;
      lost_q     <= '0;
      veto_cnt_q <= '0;
      skip_q     <= '0;
      raw_prev_q <= 1'b0;
      edge_q     <= 1'b0;
      veto_q     <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      ts_cap_q   <= ts_cap_d;
      tid_q      <= tid_d;
      presc_q    <= presc_d;
      hold_q     <= hold_d;
      lost_q     <= lost_d;
      veto_cnt_q <= veto_cnt_d;
      skip_q     <= skip_d;
      raw_prev_q <= raw_prev_d;
      edge_q     <= edge_d;
      veto_q     <= veto_d;
    end
  end

  tlu_evt_fifo #(
    .WIDTH (TID_W + TS_W),
    .DEPTH (EVT_DEPTH)
  ) u_evt_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .flush     (START),
    .push      (push),
    .push_data ({tid_q, ts_cap_q}),
    .pop       (EVT_READY),
    .full      (fifo_full),
    .valid     (fifo_valid),
    .data      (fifo_data)
  );

  assign TRIG      = fire;
  assign TRIG_ID   = tid_q;
  assign EVT_VALID = fifo_valid;
  assign EVT_DATA  = fifo_data;
  assign STAT_CNT  = {lost_q, veto_cnt_q, skip_q};
  assign DBG_STATE = state_q;

endmodule

// File: doc/tlu_trigger_core.md
TLU_TRIGGER_CORE -- requirements
Module: tlu_trigger_core

Interface
REQ-001 Parameter N_IN, default 4: number of beam trigger inputs, range 1..8.
REQ-002 Parameter N_OUT, default 6: number of DUT outputs, range 1..16.
REQ-003 Parameter TID_W, default 32: trigger ID width.
REQ-004 Parameter TS_W, default 64: timestamp width.
REQ-005 Parameter EVT_DEPTH, default 8: event FIFO depth, power of 2, at least 2.
REQ-006 CLK  in  1  single system clock.
REQ-007 RST_N  in  1  synchronous, active-low reset.
REQ-008 START  in  1  one-cycle run start.
REQ-009 CONF_ENABLE  in  1  trigger generation enable.
REQ-010 IN_VALID  in  N_IN  per-channel rising edge seen within the valid window.
REQ-011 IN_LE_REL  in  N_IN*8  per-channel CLK cycles since the last rising edge.
REQ-012 CONF_EN_INPUT  in  N_IN  channels required in the coincidence.
REQ-013 CONF_VETO_INPUT  in  N_IN  channels acting as veto.
REQ-014 CONF_MAX_LE_DIST  in  8  coincidence window in cycles.
REQ-015 CONF_PRESCALE  in  16  fire once per CONF_PRESCALE+1 accepted coincidences.
REQ-016 CONF_HOLDOFF  in  8  dead cycles after each trigger.
REQ-017 CONF_EN_OUTPUT  in  N_OUT  DUT outputs whose readiness is required.
REQ-018 DUT_READY  in  N_OUT  per-DUT ready from the transmitters.
REQ-019 TRIG  out  1  one-cycle trigger pulse.
REQ-020 TRIG_ID  out  TID_W  ID of the current or next trigger.
REQ-021 EVT_VALID / EVT_READY  out / in  1 / 1  event stream handshake.
REQ-022 EVT_DATA  out  TID_W+TS_W  event word, {trigger ID, timestamp}.
REQ-023 STAT_CNT  out  24  {LOST, VETO, SKIP} counters, 8 bits each.

Function
REQ-024 TIME_STAMP shall increment every cycle from 1 and saturate at all-ones.
REQ-025 RAW shall be true when all of the following hold: CONF_EN_INPUT is non-zero; every enabled input is valid; (max − min) of IN_LE_REL over enabled inputs is less than CONF_MAX_LE_DIST.
REQ-026 VETO shall be the OR of (IN_VALID & CONF_VETO_INPUT).
REQ-027 EDGE shall be the registered RAW rising edge; TIME_STAMP shall be captured into TS_CAP on the cycle EDGE is asserted.
REQ-028 The FSM shall have states IDLE, ARMED, FIRE and HOLDOFF; IDLE shall go to ARMED when CONF_ENABLE=1.
REQ-029 In ARMED on EDGE the actions shall take the following priority:
  - VETO: VETO counter +1.
  - Otherwise, any enabled DUT_READY low: SKIP counter +1.
  - Otherwise, prescale count equal to CONF_PRESCALE: clear the count and go to FIRE.
  - Otherwise: increment the prescale count.
REQ-030 FIRE shall last one cycle and shall:
  - assert TRIG=1;
  - push {TRIG_ID, TS_CAP};
  - increment TRIG_ID (modulo 2^TID_W) on the following cycle;
  - then go to HOLDOFF if CONF_HOLDOFF is non-zero, otherwise to ARMED.
REQ-031 HOLDOFF shall last exactly CONF_HOLDOFF cycles and then return to ARMED; each EDGE during HOLDOFF shall increment the SKIP counter.
REQ-032 Latency: RAW first true at cycle n shall produce TRIG high at cycle n+2.
REQ-033 CONF_ENABLE=0 shall force IDLE on the next cycle; a FIRE already in progress shall still complete.
REQ-034 A push while the FIFO is full shall be dropped and shall increment the LOST counter; fullness shall be evaluated before a same-cycle pop.
REQ-035 EVT_VALID shall equal FIFO not-empty; a pop shall occur when EVT_VALID and EVT_READY are both high; EVT_DATA shall hold stable while stalled.
REQ-036 All counters shall saturate at 8'hFF.
REQ-037 START shall override all same-cycle events and shall:
  - set TIME_STAMP to 1;
  - clear TRIG_ID, the prescale count and all counters;
  - flush the FIFO;
  - put the FSM in IDLE.

Reset
REQ-038 With RST_N low at a CLK edge, the block shall enter the same state as START, and TRIG, EVT_VALID and STAT_CNT shall be 0.

Configuration
REQ-039 With TLU_TEST_PULSE_EN defined, an input TEST_PULSE shall exist and RAW shall be RAW OR TEST_PULSE, with VETO still applied; without the macro, neither the port nor the logic shall exist.

Structure
REQ-040 Package tlu_pkg shall hold the FSM state enum and the counter width constant (8).
REQ-041 The event FIFO shall be the sub-module tlu_evt_fifo, with parameters width and depth.

Verification
REQ-042 Test 1: N_IN=4, enables 4'b0011, inputs 0 and 1 valid with LE_REL 5 and 7, window 4 -> TRIG 2 cycles later, event {0, TS_CAP}.
REQ-043 Test 2: same inputs with LE_REL 5 and 12 -> no TRIG, no event.
REQ-044 Test 3: veto on channel 3 with channel 3 valid during a coincidence -> VETO counter=1, no TRIG.
REQ-045 Test 4: prescale 2, six coincidence edges spaced 20 cycles, holdoff 5 -> TRIG on edges 3 and 6, TRIG_ID ends at 2.
REQ-046 Test 5: EVT_READY held 0, EVT_DEPTH+3 triggers -> LOST=3, then drain yields IDs 0..EVT_DEPTH-1 in order.
